// File: rtl/track_writeback.sv
// track_writeback: streams a modified Disk II NIB track buffer back to the mounted image over hps_io sd_wr/sd_ack.
// Optional per-sector dirty tracking: `define TRACK_WB_DIRTY_SECTOR_EN (default build writes the whole track).
module track_writeback #(
    parameter int unsigned SECTORS = 13
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [5:0]  track_cur,
    input  logic        dirty_mark,
    input  logic [3:0]  dirty_sec,
    input  logic        flush,
    output logic        flush_done,
    output logic        busy,
    output logic        cpu_wait,
    input  logic        img_present,
    input  logic        img_readonly,
    input  logic        img_mounted,
    output logic [31:0] sd_lba,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    output logic [7:0]  sd_buff_din,
    output logic [12:0] buf_addr,
    input  logic [7:0]  buf_dout
);
    localparam logic [3:0] LAST_SEC = 4'(SECTORS - 1);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t     state;
    logic [5:0] trk;
    logic [3:0] sec;
    logic       old_ack;
    logic       ack_rise;
    logic       ack_fall;
    logic       has_dirty;
    logic       more;
    logic [3:0] first_sec;
    logic [3:0] next_sec;
    logic       start_wr;
    logic       advance;

    assign ack_rise    = sd_ack & ~old_ack;
    assign ack_fall    = ~sd_ack & old_ack;
    assign buf_addr    = {sec, sd_buff_addr};
    assign sd_buff_din = buf_dout;
    assign cpu_wait    = busy;

    assign start_wr = (state == IDLE) && flush && has_dirty && img_present
                      && !img_readonly && !img_mounted;
    assign advance  = (state == XFER) && ack_fall && sd_wr && !img_mounted;

    function automatic logic [31:0] lba(input logic [5:0] t, input logic [3:0] s);
        return 32'(t) * 32'(SECTORS) + 32'(s);
    endfunction

`ifdef TRACK_WB_DIRTY_SECTOR_EN
    logic [SECTORS-1:0] dirty;

    // Descending scan so the lowest set bit (above sec for next_sec) wins.
    always_comb begin
        has_dirty = |dirty;
        first_sec = '0;
        next_sec  = sec;
        more      = 1'b0;
        for (int unsigned i = SECTORS; i > 0; i--) begin
            if (dirty[i-1]) begin
                first_sec = 4'(i - 1);
                if (4'(i - 1) > sec) begin
                    next_sec = 4'(i - 1);
                    more     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset || img_mounted) begin
            dirty <= '0;
        end else begin
            if (start_wr)
                dirty[first_sec] <= 1'b0;
            else if (advance)
                dirty[next_sec] <= 1'b0;
            if (dirty_mark && dirty_sec <= LAST_SEC)
                dirty[dirty_sec] <= 1'b1;
        end
    end
`else
    logic dirty;
    logic unused_dirty_sec;

    assign unused_dirty_sec = ^dirty_sec;

    always_comb begin
        has_dirty = dirty;
        first_sec = '0;
        next_sec  = sec + 4'd1;
        more      = (sec != LAST_SEC);
    end

    // A mark in the same cycle as the flush start keeps the buffer dirty.
    always_ff @(posedge clk_sys) begin
        if (reset || img_mounted)
            dirty <= 1'b0;
        else if (dirty_mark)
            dirty <= 1'b1;
        else if (start_wr)
            dirty <= 1'b0;
    end
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            trk        <= '0;
            sec        <= '0;
            old_ack    <= 1'b0;
            sd_wr      <= 1'b0;
            sd_lba     <= '0;
            busy       <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            old_ack    <= sd_ack;
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        busy <= 1'b1;
                        if (start_wr) begin
                            trk    <= track_cur;
                            sec    <= first_sec;
                            sd_lba <= lba(track_cur, first_sec);
                            sd_wr  <= 1'b1;
                            state  <= REQ;
                        end else begin
                            state  <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (ack_rise) begin
                        state <= XFER;
                        if (!more)
                            sd_wr <= 1'b0;
                    end
                    // A remount aborts the stream; an already-acked sector still completes.
                    if (img_mounted) begin
                        sd_wr <= 1'b0;
                        if (!sd_ack)
                            state <= DONE;
                    end
                end
                XFER: begin
                    if (img_mounted)
                        sd_wr <= 1'b0;
                    if (ack_fall) begin
                        if (!sd_wr || img_mounted) begin
                            state <= DONE;
                        end else begin
                            sec    <= next_sec;
                            sd_lba <= lba(trk, next_sec);
                            state  <= REQ;
                        end
                    end
                end
                DONE: begin
                    flush_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
